// File: rtl/sched_if.sv
// sched_if: handshake and operand-memory bus of the systolic_sched sequencer.
// The master modport belongs to the scheduler; the slave modport belongs to
// the memories/array side.
// The stall signal exists only when SCHED_STALL_EN is defined.
interface sched_if #(
  parameter int N      = 4,
  parameter int ADDR_W = 4
);
  logic              start;
`ifdef SCHED_STALL_EN
  logic              stall;
`endif
  logic              rd_en_A;
  logic [ADDR_W-1:0] rd_addr_A;
  logic              rd_en_B;
  logic [ADDR_W-1:0] rd_addr_B;
  logic [N*N-1:0]    init_pe;
  logic              tile_last;
  logic              busy;
  logic              done;

  modport master (
    input  start,
`ifdef SCHED_STALL_EN
    input  stall,
`endif
    output rd_en_A, rd_addr_A, rd_en_B, rd_addr_B,
    output init_pe, tile_last, busy, done
  );

  modport slave (
    output start,
`ifdef SCHED_STALL_EN
    output stall,
`endif
    input  rd_en_A, rd_addr_A, rd_en_B, rd_addr_B,
    input  init_pe, tile_last, busy, done
  );
endinterface

// File: rtl/systolic_sched.sv
// systolic_sched: sequencer for an NxN output-stationary systolic array
// computing D = A*B on MxM operands, as (M/N)^2 output tiles.
// It streams A/B read addresses tile by tile, emits skewed per-PE
// accumulator-init pulses that close each tile, and pulses done once the
// last tile has flushed out of PE[N-1][N-1].
// Optional feature macro: SCHED_STALL_EN (adds a stall input that freezes
// address streaming for the cycles in which it is high).
module systolic_sched #(
  parameter int N      = 4,
  parameter int M      = 8,
  parameter int ADDR_W = $clog2(M * M / N)
) (
  input logic     clk,
  input logic     rst,
  sched_if.master bus
);
  localparam int T     = M / N;
  localparam int K_W   = (M > 1) ? $clog2(M) : 1;
  localparam int T_W   = (T > 1) ? $clog2(T) : 1;
  localparam int D     = 2 * N - 1;
  localparam int CNT_W = $clog2(T * T + 1);

  localparam logic [K_W-1:0]   K_LAST   = K_W'(M - 1);
  localparam logic [T_W-1:0]   T_LAST   = T_W'(T - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(T * T - 1);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;

  state_t            state;
  logic [K_W-1:0]    k;
  logic [T_W-1:0]    ia;
  logic [T_W-1:0]    jb;
  logic [CNT_W-1:0]  done_cnt;
  logic              rd_en;
  logic [ADDR_W-1:0] addr_a;
  logic [ADDR_W-1:0] addr_b;
  logic              tile_last;
  logic              busy;
  logic              done;
  logic              init_base;
  logic [D-1:0]      skew_sr;
  logic              hold;

`ifdef SCHED_STALL_EN
  assign hold = bus.stall;
`else
  assign hold = 1'b0;
`endif

  // Main FSM: tile/k counters, address issue, tile completion counting.
  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      k         <= '0;
      ia        <= '0;
      jb        <= '0;
      done_cnt  <= '0;
      rd_en     <= 1'b0;
      addr_a    <= '0;
      addr_b    <= '0;
      tile_last <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          rd_en     <= 1'b0;
          tile_last <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
          if (bus.start) begin
            state    <= STREAM;
            k        <= '0;
            ia       <= '0;
            jb       <= '0;
            done_cnt <= '0;
          end
        end

        STREAM: begin
          busy <= 1'b1;
          if (skew_sr[D-1]) done_cnt <= done_cnt + CNT_W'(1);
          if (hold) begin
            rd_en     <= 1'b0;
            tile_last <= 1'b0;
          end else begin
            rd_en     <= 1'b1;
            addr_a    <= ADDR_W'(ia) * ADDR_W'(M) + ADDR_W'(k);
            addr_b    <= ADDR_W'(jb) * ADDR_W'(M) + ADDR_W'(k);
            tile_last <= (k == K_LAST);
            if (k == K_LAST) begin
              k <= '0;
              if (jb == T_LAST) begin
                jb <= '0;
                if (ia == T_LAST) begin
                  ia    <= '0;
                  state <= DRAIN;
                end else begin
                  ia <= ia + T_W'(1);
                end
              end else begin
                jb <= jb + T_W'(1);
              end
            end else begin
              k <= k + K_W'(1);
            end
          end
        end

        DRAIN: begin
          rd_en     <= 1'b0;
          tile_last <= 1'b0;
          if (skew_sr[D-1]) begin
            done_cnt <= done_cnt + CNT_W'(1);
            // The final flush pulse is the one that brings done_cnt to T*T;
            // leaving on it puts done in the very cycle after that flush.
            if (done_cnt == CNT_LAST) begin
              state <= DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end
          end
        end

        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

  // Init skew chain: init_base lags tile_last by the memory read latency,
  // skew_sr[d] lags init_base by d+1 cycles.
  // NOTE: the whole chain is reset so no pulse of an aborted run survives rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      init_base <= 1'b0;
      skew_sr   <= '0;
    end else begin
      init_base <= tile_last;
      skew_sr   <= D'({skew_sr, init_base});
    end
  end

  // Fan the skew chain out to PEs: PE[x][y] sees the tap at depth x+y.
  // NOTE: the default assignment first keeps this purely combinational.
  always_comb begin
    bus.init_pe = '0;
    for (int x = 0; x < N; x++) begin
      for (int y = 0; y < N; y++) begin
        bus.init_pe[x*N+y] = skew_sr[x+y];
      end
    end
  end

  assign bus.rd_en_A   = rd_en;
  assign bus.rd_en_B   = rd_en;
  assign bus.rd_addr_A = addr_a;
  assign bus.rd_addr_B = addr_b;
  assign bus.tile_last = tile_last;
  assign bus.busy      = busy;
  assign bus.done      = done;
endmodule
